// File: rtl/ahb_lite_pkg.sv
// rtl/ahb_lite_pkg.sv - AHB-Lite transfer/response encodings and default-slave state encoding
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [1:0] D_IDLE = 2'd0;
    localparam logic [1:0] D_ERR1 = 2'd1;
    localparam logic [1:0] D_ERR2 = 2'd2;

    function automatic logic is_active(input logic [1:0] trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_lite_default_slave.sv
// rtl/ahb_lite_default_slave.sv - default slave giving a two-cycle ERROR to unmapped active transfers
module ahb_lite_default_slave
    import ahb_lite_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       HSEL_dflt,
    input  logic [1:0] HTRANS,
    input  logic       HREADY,
    output logic       HREADYOUT,
    output logic       HRESP
);

    logic [1:0] state;
    logic       start_err;

    assign start_err = HSEL_dflt && is_active(HTRANS) && HREADY;

    // ERR1 always advances: it is the wait cycle that the default slave itself inserts.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state <= D_IDLE;
        end else begin
            case (state)
                D_IDLE:  if (start_err) state <= D_ERR1;
                D_ERR1:  state <= D_ERR2;
                D_ERR2:  if (HREADY) state <= start_err ? D_ERR1 : D_IDLE;
                default: state <= D_IDLE;
            endcase
        end
    end

    always_comb begin
        HREADYOUT = (state != D_ERR1);
        HRESP     = (state == D_IDLE) ? HRESP_OKAY : HRESP_ERROR;
    end

endmodule

// File: rtl/ahb_lite_decode_mux.sv
// rtl/ahb_lite_decode_mux.sv - AHB-Lite address decoder and slave-response multiplexer
module ahb_lite_decode_mux
    import ahb_lite_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int N_SLV   = 4,
    parameter int SEL_MSB = 31,
    parameter int SEL_LSB = 28
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic [ADDR_W-1:0]       HADDR,
    input  logic [1:0]              HTRANS,
    output logic [N_SLV-1:0]        HSEL,
    input  logic [N_SLV*DATA_W-1:0] HRDATA_S,
    input  logic [N_SLV-1:0]        HRESP_S,
    input  logic [N_SLV-1:0]        HREADYOUT_S,
    output logic [DATA_W-1:0]       HRDATA,
    output logic                    HRESP,
    output logic                    HREADY
);

    localparam int IW = SEL_MSB - SEL_LSB + 1;
    localparam int SW = $clog2(N_SLV + 1);

    logic [IW-1:0] idx;
    logic          mapped;
    logic [SW-1:0] dp_sel_d;
    logic [SW-1:0] dp_sel;
    logic          dflt_ready;
    logic          dflt_resp;
    logic          unused_addr;

    assign idx         = HADDR[SEL_MSB:SEL_LSB];
    assign mapped      = (idx < IW'(N_SLV));
    assign dp_sel_d    = mapped ? SW'(idx) : SW'(N_SLV);
    assign unused_addr = ^HADDR;

    always_comb begin
        HSEL = '0;
        for (int i = 0; i < N_SLV; i++) begin
            HSEL[i] = (idx == IW'(i));
        end
    end

    // Index N_SLV selects the built-in default slave.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            dp_sel <= SW'(N_SLV);
        end else if (HREADY) begin
            dp_sel <= dp_sel_d;
        end
    end

    ahb_lite_default_slave u_dflt (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL_dflt (!mapped),
        .HTRANS    (HTRANS),
        .HREADY    (HREADY),
        .HREADYOUT (dflt_ready),
        .HRESP     (dflt_resp)
    );

    always_comb begin
        HRDATA = '0;
        HRESP  = dflt_resp;
        HREADY = dflt_ready;
        for (int i = 0; i < N_SLV; i++) begin
            if (dp_sel == SW'(i)) begin
                HRDATA = HRDATA_S[i*DATA_W +: DATA_W];
                HRESP  = HRESP_S[i];
                HREADY = HREADYOUT_S[i];
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_decode_mux.sv
// tb/tb_ahb_lite_decode_mux.sv - directed self-checking bench for ahb_lite_decode_mux
module tb_ahb_lite_decode_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // N_SLV=4, DATA_W=32 instance
    logic         rstn;
    logic [31:0]  haddr;
    logic [1:0]   htrans;
    logic [3:0]   hsel;
    logic [127:0] hrdata_s;
    logic [3:0]   hresp_s;
    logic [3:0]   hreadyout_s;
    logic [31:0]  hrdata;
    logic         hresp;
    logic         hready;

    // N_SLV=2, DATA_W=64 instance
    logic         rstn2;
    logic [31:0]  haddr2;
    logic [1:0]   htrans2;
    logic [1:0]   hsel2;
    logic [127:0] hrdata_s2;
    logic [1:0]   hresp_s2;
    logic [1:0]   hreadyout_s2;
    logic [63:0]  hrdata2;
    logic         hresp2;
    logic         hready2;

    ahb_lite_decode_mux #(.DATA_W(32), .ADDR_W(32), .N_SLV(4), .SEL_MSB(31), .SEL_LSB(28)) dut4 (
        .HCLK(clk), .HRESETn(rstn), .HADDR(haddr), .HTRANS(htrans), .HSEL(hsel),
        .HRDATA_S(hrdata_s), .HRESP_S(hresp_s), .HREADYOUT_S(hreadyout_s),
        .HRDATA(hrdata), .HRESP(hresp), .HREADY(hready)
    );

    ahb_lite_decode_mux #(.DATA_W(64), .ADDR_W(32), .N_SLV(2), .SEL_MSB(31), .SEL_LSB(28)) dut2 (
        .HCLK(clk), .HRESETn(rstn2), .HADDR(haddr2), .HTRANS(htrans2), .HSEL(hsel2),
        .HRDATA_S(hrdata_s2), .HRESP_S(hresp_s2), .HREADYOUT_S(hreadyout_s2),
        .HRDATA(hrdata2), .HRESP(hresp2), .HREADY(hready2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn        = 1'b0;
        haddr       = 32'h1000_0000;
        htrans      = 2'b00;
        hrdata_s    = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_1111};
        hresp_s     = 4'b0000;
        hreadyout_s = 4'b1111;
        rstn2        = 1'b0;
        haddr2       = 32'h0;
        htrans2      = 2'b00;
        hrdata_s2    = {64'hDEAD_BEEF_CAFE_F00D, 64'h1111_1111_1111_1111};
        hresp_s2     = 2'b00;
        hreadyout_s2 = 2'b11;

        // 1: reset
        tick(); tick();
        check("rst_hready", hready, 1);
        check("rst_hresp", hresp, 0);
        check("rst_hrdata", hrdata, 0);
        check("rst_hsel", hsel, 4'b0010);
        rstn = 1'b1;

        // 2: slave1 stalls two cycles
        haddr = 32'h1000_0004; htrans = 2'b10; hreadyout_s[1] = 1'b0;
        #1 check("t2_hsel", hsel, 4'b0010);
        tick();
        haddr = 32'h0000_0000; htrans = 2'b00;
        #1 check("t2_wait1", hready, 0);
        check("t2_wait1_data", hrdata, 32'hDEAD_BEEF);
        tick();
        check("t2_wait2", hready, 0);
        hreadyout_s[1] = 1'b1;
        #1 check("t2_done", hready, 1);
        check("t2_data", hrdata, 32'hDEAD_BEEF);

        // 3: pipelined slave0 then slave2
        htrans = 2'b10;
        tick();
        haddr = 32'h2000_0000;
        #1 check("t3_hsel", hsel, 4'b0100);
        check("t3_s0_data", hrdata, 32'h1111_1111);
        check("t3_s0_ready", hready, 1);
        tick();
        htrans = 2'b00;
        #1 check("t3_s2_data", hrdata, 32'h2222_2222);
        check("t3_s2_ready", hready, 1);

        // 4: unmapped NONSEQ
        haddr = 32'h7000_0000; htrans = 2'b10;
        #1 check("t4_hsel", hsel, 4'b0000);
        tick();
        haddr = 32'h0; htrans = 2'b00;
        #1 check("t4_err1_ready", hready, 0);
        check("t4_err1_resp", hresp, 1);
        check("t4_err1_data", hrdata, 0);
        tick();
        check("t4_err2_ready", hready, 1);
        check("t4_err2_resp", hresp, 1);
        tick();
        check("t4_ok_resp", hresp, 0);
        check("t4_ok_ready", hready, 1);

        // 5: unmapped IDLE, then two back-to-back unmapped NONSEQs
        haddr = 32'h7000_0000; htrans = 2'b00;
        tick();
        check("t5_idle_ready", hready, 1);
        check("t5_idle_resp", hresp, 0);
        htrans = 2'b10;
        tick();
        check("t5_a_err1_ready", hready, 0);
        check("t5_a_err1_resp", hresp, 1);
        tick();
        check("t5_a_err2_ready", hready, 1);
        check("t5_a_err2_resp", hresp, 1);
        tick();
        htrans = 2'b00;
        #1 check("t5_b_err1_ready", hready, 0);
        check("t5_b_err1_resp", hresp, 1);
        tick();
        check("t5_b_err2_ready", hready, 1);
        check("t5_b_err2_resp", hresp, 1);
        tick();
        check("t5_end_resp", hresp, 0);

        // 6: reset during ERR1
        htrans = 2'b10;
        tick();
        check("t6_err1_ready", hready, 0);
        rstn = 1'b0;
        tick();
        check("t6_rst_ready", hready, 1);
        check("t6_rst_resp", hresp, 0);
        check("t6_rst_data", hrdata, 0);
        rstn = 1'b1; htrans = 2'b00;
        tick();
        check("t6_after_resp", hresp, 0);
        check("t6_after_ready", hready, 1);

        // N_SLV=2, DATA_W=64: stall, pipeline, unmapped
        rstn2 = 1'b1;
        haddr2 = 32'h1000_0000; htrans2 = 2'b10; hreadyout_s2[1] = 1'b0;
        #1 check("w_hsel", hsel2, 2'b10);
        tick();
        haddr2 = 32'h0; htrans2 = 2'b10;
        #1 check("w_wait1", hready2, 0);
        tick();
        check("w_wait2", hready2, 0);
        hreadyout_s2[1] = 1'b1;
        #1 check("w_done", hready2, 1);
        check("w_data", hrdata2, 64'hDEAD_BEEF_CAFE_F00D);
        tick();
        haddr2 = 32'h1000_0000;
        #1 check("w_s0_data", hrdata2, 64'h1111_1111_1111_1111);
        tick();
        haddr2 = 32'h2000_0000;
        #1 check("w_s1_data", hrdata2, 64'hDEAD_BEEF_CAFE_F00D);
        check("w_unmapped_hsel", hsel2, 2'b00);
        tick();
        htrans2 = 2'b00;
        #1 check("w_err1_ready", hready2, 0);
        check("w_err1_resp", hresp2, 1);
        check("w_err1_data", hrdata2, 0);
        tick();
        check("w_err2_ready", hready2, 1);
        check("w_err2_resp", hresp2, 1);
        tick();
        check("w_ok_resp", hresp2, 0);
        check("w_ok_ready", hready2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
